// File: rtl/mem_block_mover.sv
// Block copy / block fill initiator for the nano-risc data memory port.
// One byte per READ/WRITE pair in copy mode, one byte per cycle in fill mode.
module mem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] length,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] cnt_q;
    logic          mode_q;
    logic [DW-1:0] buf_q;
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            buf_q   <= '0;
            sum_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        cnt_q  <= length;
                        mode_q <= mode;
                        sum_q  <= '0;
                        if (length == '0) begin
                            state_q <= DONE;
                        end else if (mode) begin
                            buf_q   <= fill_val;
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    buf_q   <= mem_rdata;
                    state_q <= WRITE;
                end
                WRITE: begin
                    sum_q <= sum_q + buf_q;
                    src_q <= src_q + AW'(1);
                    dst_q <= dst_q + AW'(1);
                    cnt_q <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_q <= DONE;
                    end else if (mode_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q <= READ;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = (state_q == WRITE) ? buf_q : '0;
    assign mem_addr  = (state_q == READ)  ? src_q :
                       (state_q == WRITE) ? dst_q : '0;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover: vector table plus hand-written
// sequences for ignored start and mid-transfer reset.
module tb_mem_block_mover;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    logic [7:0] wlog [1024];
    int         we_total = 0;
    int         done_total = 0;
    int         n_pass = 0;
    int         n_chk = 0;

    always #5 clk = ~clk;

    mem_block_mover #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog[we_total % 1024] = mem_addr;
            we_total = we_total + 1;
        end
    end

    always @(negedge clk) begin
        if (done) done_total = done_total + 1;
    end

    typedef struct {
        string      name;
        logic       m;
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] l;
        logic [7:0] f;
        logic [7:0] exp_sum;
        int         exp_lat;
        int         exp_we;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_val = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int base;
        int dbase;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1] = 8'd24;
        mem[2] = 8'd7;
        mem[8'h30] = 8'd9;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_val = '0;

        vecs[0] = '{"copy2",    1'b0, 8'h01, 8'h10, 8'd2, 8'h00, 8'd31,  5, 2};
        vecs[1] = '{"fill4",    1'b1, 8'h00, 8'h20, 8'd4, 8'hA5, 8'h94,  5, 4};
        vecs[2] = '{"len0",     1'b1, 8'h00, 8'h70, 8'd0, 8'h33, 8'h00,  1, 0};
        vecs[3] = '{"wrapfill", 1'b1, 8'h00, 8'hFE, 8'd3, 8'h01, 8'd3,   4, 3};
        vecs[4] = '{"overlap",  1'b0, 8'h30, 8'h31, 8'd3, 8'h00, 8'd27,  7, 3};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            base = we_total;
            issue(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].l, vecs[v].f);
            wait_done(lat);
            chk({vecs[v].name, "_lat"}, lat, vecs[v].exp_lat);
            chk({vecs[v].name, "_sum"}, sum, vecs[v].exp_sum);
            chk({vecs[v].name, "_busy"}, busy, 1);
            chk({vecs[v].name, "_we"}, we_total - base, vecs[v].exp_we);
            if (v == 3) begin
                chk("wrap_a0", wlog[base % 1024], 8'hFE);
                chk("wrap_a1", wlog[(base + 1) % 1024], 8'hFF);
                chk("wrap_a2", wlog[(base + 2) % 1024], 8'h00);
            end
            @(negedge clk);
            chk({vecs[v].name, "_idle"}, busy, 0);
        end

        chk("copy_m10", mem[8'h10], 24);
        chk("copy_m11", mem[8'h11], 7);
        for (int i = 0; i < 4; i++) chk("fill_m2x", mem[8'h20 + i], 8'hA5);
        chk("len0_m70", mem[8'h70], 0);
        chk("wrap_mFE", mem[8'hFE], 1);
        chk("wrap_mFF", mem[8'hFF], 1);
        chk("wrap_m00", mem[8'h00], 1);
        chk("ovl_m31", mem[8'h31], 9);
        chk("ovl_m32", mem[8'h32], 9);
        chk("ovl_m33", mem[8'h33], 9);

        base = we_total;
        issue(1'b0, 8'h01, 8'h40, 8'd2, 8'h00);
        @(negedge clk);
        mode = 1'b1; dst_addr = 8'h50; length = 8'd5; fill_val = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 3; c <= 600; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("ign_lat", lat, 5);
        chk("ign_sum", sum, 31);
        chk("ign_we", we_total - base, 2);
        @(negedge clk);
        chk("ign_m40", mem[8'h40], 24);
        chk("ign_m41", mem[8'h41], 7);
        chk("ign_m50", mem[8'h50], 0);

        base = we_total;
        dbase = done_total;
        issue(1'b1, 8'h00, 8'h60, 8'd4, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        chk("rmid_we_pre", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rmid_we", mem_we, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rmid_done", done_total - dbase, 0);
        chk("rmid_wecnt", we_total - base, 1);
        chk("rmid_m60", mem[8'h60], 8'h5A);
        chk("rmid_m61", mem[8'h61], 0);
        chk("rmid_m62", mem[8'h62], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
